// File: rtl/btn_pkg.sv
// Shared definitions for board push-button input handling.
package btn_pkg;

   // Debounce FSM state encoding
   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // Default timing for the 100 MHz board clock
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;    // 10 ms
   localparam int unsigned DEF_LONG_CYCLES     = 100000000;  // 1 s

endpackage : btn_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
module sync_2ff #(
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture; both stages reset to the idle level of the input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : sync_2ff

// File: rtl/button_reader.sv
// Push-button reader: synchroniser, counter debouncer, press/release/long-press events.
module button_reader
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_pin,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press
);

   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

   // The count seen in the cycle whose increment reaches DEBOUNCE_CYCLES-1;
   // accepting on that edge gives 2 + DEBOUNCE_CYCLES cycles pin-to-event.
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   btn_state_t        state, state_next;
   logic [DB_W-1:0]   db_cnt, db_next;
   logic [HOLD_W-1:0] hold_cnt, hold_next;

   logic sync_q;
   logic btn_s;
   logic pressed_c, press_pulse_c, release_pulse_c, long_press_c;

   sync_2ff #(
      .RST_VAL (ACTIVE_LOW)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_pin),
      .q   (sync_q)
   );

   // Pressed-high view of the synchronised pin
   assign btn_s = sync_q ^ ACTIVE_LOW;

   // State, counter and registered-output update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= RELEASED;
         db_cnt        <= '0;
         hold_cnt      <= '0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
      end else begin
         state         <= state_next;
         db_cnt        <= db_next;
         hold_cnt      <= hold_next;
         pressed       <= pressed_c;
         press_pulse   <= press_pulse_c;
         release_pulse <= release_pulse_c;
         long_press    <= long_press_c;
      end
   end

   // Next-state and counter logic for the debouncer
   always_comb begin
      state_next = state;
      db_next    = db_cnt;
      hold_next  = hold_cnt;
      case (state)
         RELEASED: begin
            if (btn_s) begin
               state_next = PRESS_WAIT;
               db_next    = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_next = RELEASED;
            end else begin
               db_next = db_cnt + DB_W'(1);
               if (db_cnt == DB_LAST) begin
                  state_next = HELD;
                  hold_next  = '0;
               end
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_next = RELEASE_WAIT;
               db_next    = '0;
            end else if (hold_cnt != HOLD_MAX) begin
               hold_next = hold_cnt + HOLD_W'(1);
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_next = HELD;
            end else begin
               db_next = db_cnt + DB_W'(1);
               if (db_cnt == DB_LAST) begin
                  state_next = RELEASED;
               end
            end
         end
         default: begin
            state_next = RELEASED;
         end
      endcase
   end

   // Output decode, registered on the next edge
   always_comb begin
      pressed_c       = 1'b0;
      press_pulse_c   = 1'b0;
      release_pulse_c = 1'b0;
      long_press_c    = 1'b0;
      pressed_c       = (state_next == HELD) || (state_next == RELEASE_WAIT);
      press_pulse_c   = (state == PRESS_WAIT) && btn_s && (db_cnt == DB_LAST);
      release_pulse_c = (state == RELEASE_WAIT) && !btn_s && (db_cnt == DB_LAST);
      // Saturation means hold_cnt passes HOLD_LAST->HOLD_MAX only once per press
      long_press_c    = (state == HELD) && btn_s && (hold_cnt == HOLD_LAST);
   end

endmodule : button_reader

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side counterpart to the board LED drivers: reads one active-low push-button pin and reports clean events to user logic.
- Pipeline: 2-FF synchroniser, counter-based debouncer, press/release/long-press event generator.
- Sits between the board button pin and workshop logic, e.g. to toggle active-low RGB LED outputs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must hold a new level before it is accepted (10 ms at 100 MHz); legal range >= 2.
- LONG_CYCLES, 100000000, cycles of accepted press before long_press fires (1 s at 100 MHz); must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately; release is synchronised externally.
- btn_pin  input  1  raw, asynchronous button pin.
- pressed  output  1  debounced level; 1 = button held.
- press_pulse  output  1  one-cycle strobe on an accepted press.
- release_pulse  output  1  one-cycle strobe on an accepted release.
- long_press  output  1  one-cycle strobe when a press has lasted LONG_CYCLES.

Behaviour:
- Reset (rst=0): sync flops load the "released" level (1 if ACTIVE_LOW else 0); state=RELEASED; both counters=0; all outputs 0.
- Synchroniser: two flops; raw_n = sync2 XOR ACTIVE_LOW gives a pressed-high level btn_s. Latency from pin to btn_s is 2 cycles.
- FSM states:
  - RELEASED: if btn_s=1, clear db_cnt and go to PRESS_WAIT.
  - PRESS_WAIT: if btn_s=0, return to RELEASED (bounce, no event). Else db_cnt++. When db_cnt reaches DEBOUNCE_CYCLES-1 while btn_s=1, go to HELD, assert press_pulse for 1 cycle, set pressed=1, clear hold_cnt.
  - HELD: if btn_s=0, clear db_cnt and go to RELEASE_WAIT. Otherwise hold_cnt increments, saturating at LONG_CYCLES. long_press pulses exactly once, in the cycle hold_cnt transitions to LONG_CYCLES.
  - RELEASE_WAIT: if btn_s=1, return to HELD; hold_cnt is kept, no event, and no second long_press. Else db_cnt++. When db_cnt reaches DEBOUNCE_CYCLES-1 while btn_s=0, go to RELEASED, assert release_pulse, set pressed=0.
- Latency: clean edge at pin to press_pulse/release_pulse = 2 (sync) + DEBOUNCE_CYCLES cycles.
- pressed stays 1 through RELEASE_WAIT.
- Outputs are registered; press_pulse and release_pulse are never high in the same cycle.
- Counter widths: db_cnt is $clog2(DEBOUNCE_CYCLES+1) bits; hold_cnt is $clog2(LONG_CYCLES+1) bits. No wrap: hold_cnt saturates.
- Long press counts from the press_pulse cycle, so long_press fires LONG_CYCLES cycles after press_pulse.
- A single-cycle glitch of any polarity never produces an event.
- Reset mid-press: outputs drop to 0 asynchronously and no release_pulse is generated. After rst deasserts with the button still held, a fresh press_pulse follows after full debounce.

Decomposition:
- Shared package (btn_pkg): FSM state encoding (RELEASED=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3) and default timing constants for the 100 MHz board clock.
- One sub-module, sync_2ff (parameterised reset value), reused later for other board inputs.
- Debounce FSM and counters stay in button_reader.

Test Plan (DEBOUNCE_CYCLES=8, LONG_CYCLES=40, ACTIVE_LOW=1):
- Reset: hold rst=0 with pin toggling -> all outputs 0. Release rst with pin=1 -> no events for 100 cycles.
- Clean press: pin 1->0 at cycle T -> press_pulse high for exactly 1 cycle at T+10, pressed=1 from T+10. Pin 0->1 at U -> release_pulse at U+10, pressed=0.
- Bounce: pin toggles low/high every 3 cycles for 30 cycles, then stays low -> exactly one press_pulse, 10 cycles after the final edge; no release_pulse.
- Long press: hold pin low 100 cycles -> press_pulse at T+10, single long_press at T+50, no further long_press. Release -> one release_pulse.
- Release glitch while held: pin high for 4 cycles at T+60 -> no release_pulse, pressed stays 1, no second long_press.
- Async reset mid-press: assert rst at T+30 while held -> outputs 0 within the same cycle, no release_pulse. Deassert with pin low -> press_pulse 10 cycles after deassert.
